dsp_frame_sequencer: RTL and testbench

Controller that sits between the ADC/DAC sample source and the range-detector datapath. It builds exactly-FFT_LEN-sample frames aligned to chirp start and marks each with first/last flags and a frame counter. Between frames it loads the 64-bit I/Q peak thresholds into the detector as serial nibble writes. It then waits for the detector's peak report, or a timeout, before arming for the next chirp.

---
 rtl/dsp_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dsp_frame_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_sequencer.sv
// rtl/dsp_frame_sequencer.sv - chirp-aligned FFT frame builder with threshold load and result wait
module dsp_frame_sequencer #(
    parameter int FFT_LEN   = 8192,
    parameter int TIMEOUT_W = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic [63:0]          thresh_i,
    input  logic [63:0]          thresh_q,
    input  logic [TIMEOUT_W-1:0] frame_timeout_cycles,
    input  logic                 chirp_active,
    input  logic [31:0]          s_adc_tdata,
    input  logic [31:0]          s_dac_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    output logic [31:0]          m_adc_iq_tdata,
    output logic [31:0]          m_dac_iq_tdata,
    output logic                 m_iq_tvalid,
    output logic                 m_iq_tlast,
    output logic                 m_iq_first,
    input  logic                 m_iq_tready,
    output logic [63:0]          counter_id,
    output logic [7:0]           threshold_ctrl_i,
    output logic [7:0]           threshold_ctrl_q,
    input  logic                 pk_tvalid,
    input  logic                 pk_tready,
    output logic                 busy,
    output logic [15:0]          timeout_count
);
    localparam int CNT_W = $clog2(FFT_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOAD_THRESH, ARM, STREAM, PAD, WAIT_RESULT} state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_count;
    logic [3:0]           r_nib;
    logic [63:0]          r_thr_i;
    logic [63:0]          r_thr_q;
    logic                 r_chirp_d;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [63:0]          r_counter_id;
    logic [7:0]           r_ctrl_i;
    logic [7:0]           r_ctrl_q;
    logic [15:0]          r_timeouts;
    logic                 r_busy;

    logic                 w_xfer;
    logic                 w_last;
    logic                 w_pk;
    logic                 w_timeout;
    logic                 w_wait_exit;
    logic                 w_start_load;
    logic [3:0]           w_nib_next;

    always_comb begin
        s_tready       = 1'b1;
        m_iq_tvalid    = 1'b0;
        m_adc_iq_tdata = '0;
        m_dac_iq_tdata = '0;
        case (r_state)
            STREAM: begin
                s_tready       = m_iq_tready;
                m_iq_tvalid    = s_tvalid;
                m_adc_iq_tdata = s_adc_tdata;
                m_dac_iq_tdata = s_dac_tdata;
            end
            PAD: begin
                s_tready    = 1'b0;
                m_iq_tvalid = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_xfer       = m_iq_tvalid & m_iq_tready;
    assign w_last       = (r_count == LAST_IDX);
    assign m_iq_first   = m_iq_tvalid & (r_count == '0);
    assign m_iq_tlast   = m_iq_tvalid & w_last;
    assign w_pk         = pk_tvalid & pk_tready;
    assign w_timeout    = (frame_timeout_cycles != '0) && (r_timer == frame_timeout_cycles);
    assign w_wait_exit  = (r_state == WAIT_RESULT) && (w_pk || w_timeout);
    assign w_start_load = enable && ((r_state == IDLE) || w_wait_exit);
    assign w_nib_next   = r_nib + 4'd1;

    assign counter_id       = r_counter_id;
    assign threshold_ctrl_i = r_ctrl_i;
    assign threshold_ctrl_q = r_ctrl_q;
    assign timeout_count    = r_timeouts;
    assign busy             = r_busy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_nib        <= '0;
            r_thr_i      <= '0;
            r_thr_q      <= '0;
            r_chirp_d    <= 1'b0;
            r_timer      <= '0;
            r_counter_id <= '0;
            r_ctrl_i     <= '0;
            r_ctrl_q     <= '0;
            r_timeouts   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_chirp_d <= chirp_active;
            case (r_state)
                LOAD_THRESH: begin
                    if (r_nib == 4'hF) begin
                        r_state <= ARM;
                    end else begin
                        r_nib    <= w_nib_next;
                        r_ctrl_i <= {w_nib_next, r_thr_i[{w_nib_next, 2'b00} +: 4]};
                        r_ctrl_q <= {w_nib_next, r_thr_q[{w_nib_next, 2'b00} +: 4]};
                    end
                end
                ARM: begin
                    if (chirp_active && !r_chirp_d)
                        r_state <= STREAM;
                end
                STREAM, PAD: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state      <= WAIT_RESULT;
                            r_count      <= '0;
                            r_counter_id <= r_counter_id + 64'd1;
                            r_timer      <= TIMEOUT_W'(1);
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end else if (r_state == STREAM && !chirp_active && r_count != '0) begin
                        r_state <= PAD;
                    end
                end
                WAIT_RESULT: begin
                    r_timer <= r_timer + TIMEOUT_W'(1);
                    // A peak report in the timeout cycle counts as a normal completion
                    if (w_timeout && !w_pk && r_timeouts != 16'hFFFF)
                        r_timeouts <= r_timeouts + 16'd1;
                    if (w_wait_exit && !enable) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
            // Thresholds are snapshotted here so input changes mid-load cannot tear a word
            if (w_start_load) begin
                r_state  <= LOAD_THRESH;
                r_busy   <= 1'b1;
                r_nib    <= 4'd0;
                r_thr_i  <= thresh_i;
                r_thr_q  <= thresh_q;
                r_ctrl_i <= {4'd0, thresh_i[3:0]};
                r_ctrl_q <= {4'd0, thresh_q[3:0]};
            end
        end
    end
endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// tb/tb_dsp_frame_sequencer.sv - table and scoreboard bench for dsp_frame_sequencer
`timescale 1ns/1ps
module tb_dsp_frame_sequencer;
    localparam int FFT_LEN = 16;
    localparam int TW      = 32;
    localparam logic [63:0] TI = 64'h0123456789ABCDEF;
    localparam logic [63:0] TQ = 64'hFEDCBA9876543210;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic          aresetn, enable, chirp_active, s_tvalid, s_tready;
    logic          m_iq_tvalid, m_iq_tlast, m_iq_first, m_iq_tready;
    logic          pk_tvalid, pk_tready, busy;
    logic [63:0]   thresh_i, thresh_q, counter_id;
    logic [TW-1:0] frame_timeout_cycles;
    logic [31:0]   s_adc_tdata, s_dac_tdata, m_adc_iq_tdata, m_dac_iq_tdata;
    logic [7:0]    threshold_ctrl_i, threshold_ctrl_q;
    logic [15:0]   timeout_count;

    dsp_frame_sequencer #(.FFT_LEN(FFT_LEN), .TIMEOUT_W(TW)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .thresh_i(thresh_i), .thresh_q(thresh_q),
        .frame_timeout_cycles(frame_timeout_cycles), .chirp_active(chirp_active),
        .s_adc_tdata(s_adc_tdata), .s_dac_tdata(s_dac_tdata),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_adc_iq_tdata(m_adc_iq_tdata), .m_dac_iq_tdata(m_dac_iq_tdata),
        .m_iq_tvalid(m_iq_tvalid), .m_iq_tlast(m_iq_tlast), .m_iq_first(m_iq_first),
        .m_iq_tready(m_iq_tready), .counter_id(counter_id),
        .threshold_ctrl_i(threshold_ctrl_i), .threshold_ctrl_q(threshold_ctrl_q),
        .pk_tvalid(pk_tvalid), .pk_tready(pk_tready),
        .busy(busy), .timeout_count(timeout_count)
    );

    typedef struct {
        logic [31:0] adc;
        logic [31:0] dac;
        logic        first;
        logic        last;
        logic [63:0] cid;
    } beat_t;

    typedef struct {
        int         k;
        logic [7:0] exp_i;
        logic [7:0] exp_q;
    } load_vec_t;

    beat_t     sb[$];
    beat_t     mon_e;
    load_vec_t lv[16];
    int        total = 0;
    int        bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] adc_of(input int i);
        return {16'(i + 256), 16'(32'h8000 - i)};
    endfunction

    function automatic logic [31:0] dac_of(input int i);
        return {16'(i * 3), 16'(i ^ 32'h5A5A)};
    endfunction

    always @(negedge aclk) begin
        #2;
        if (aresetn && m_iq_tvalid && m_iq_tready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got unexpected beat tlast=%0b expected none", m_iq_tlast);
            end else begin
                mon_e = sb.pop_front();
                chk("beat_adc", m_adc_iq_tdata, mon_e.adc);
                chk("beat_dac", m_dac_iq_tdata, mon_e.dac);
                chk("beat_first", m_iq_first, mon_e.first);
                chk("beat_last", m_iq_tlast, mon_e.last);
                chk("beat_cid", counter_id, mon_e.cid);
            end
        end
    end

    task automatic next_cycle();
        @(negedge aclk);
        s_tvalid     = 1'b0;
        chirp_active = 1'b0;
        pk_tvalid    = 1'b0;
        pk_tready    = 1'b0;
        m_iq_tready  = 1'b1;
        #1;
    endtask

    task automatic pk_cycle();
        @(negedge aclk);
        pk_tvalid = 1'b1;
        pk_tready = 1'b1;
        #1;
    endtask

    task automatic check_load(input logic [15:0] exp_tc);
        for (int k = 0; k < 16; k++) begin
            next_cycle();
            if (k == 0) chk("tc_at_load", timeout_count, exp_tc);
            if (k == 3) thresh_i = 64'h0;
            chk("thr_i", threshold_ctrl_i, lv[k].exp_i);
            chk("thr_q", threshold_ctrl_q, lv[k].exp_q);
            chk("busy_load", busy, 1);
        end
        thresh_i = TI;
    endtask

    task automatic run_frame(input int drop, input bit bp, input logic [63:0] cid,
                             input int en_off, input int n_push);
        int    sent    = 0;
        bit    padding = 0;
        int    guard   = 0;
        beat_t e;
        next_cycle();
        chk("arm_ready", s_tready, 1);
        chk("arm_valid", m_iq_tvalid, 0);
        chk("thr_hold", threshold_ctrl_i, lv[15].exp_i);
        @(negedge aclk);
        chirp_active = 1'b1;
        s_tvalid     = 1'b1;
        s_adc_tdata  = 32'hDEADBEEF;
        s_dac_tdata  = 32'hBADC0FFE;
        #1;
        chk("edge_valid", m_iq_tvalid, 0);
        for (int i = 0; i < n_push; i++) begin
            e.adc   = (i < drop) ? adc_of(i) : 32'h0;
            e.dac   = (i < drop) ? dac_of(i) : 32'h0;
            e.first = (i == 0);
            e.last  = (i == FFT_LEN - 1);
            e.cid   = cid;
            sb.push_back(e);
        end
        while (sb.size() > 0 && guard < 400) begin
            @(negedge aclk);
            guard++;
            chirp_active = (sent < drop);
            s_tvalid     = (sent < drop);
            s_adc_tdata  = adc_of(sent);
            s_dac_tdata  = dac_of(sent);
            m_iq_tready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent == en_off) enable = 1'b0;
            #1;
            if (padding) begin
                chk("pad_ready", s_tready, 0);
                chk("pad_valid", m_iq_tvalid, 1);
            end else begin
                chk("stream_ready", s_tready, m_iq_tready);
            end
            if (!padding && s_tvalid && m_iq_tready) sent++;
            else if (!padding && !chirp_active && sent > 0) padding = 1;
            #2;
        end
        if (guard >= 400) chk("frame_done", 64'(sb.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 16; k++) begin
            lv[k].k     = k;
            lv[k].exp_i = {4'(k), 4'(15 - k)};
            lv[k].exp_q = {4'(k), 4'(k)};
        end
        aresetn = 1'b0; enable = 1'b0; chirp_active = 1'b0;
        s_tvalid = 1'b0; s_adc_tdata = '0; s_dac_tdata = '0;
        m_iq_tready = 1'b1; pk_tvalid = 1'b0; pk_tready = 1'b0;
        thresh_i = TI; thresh_q = TQ; frame_timeout_cycles = '0;

        repeat (2) @(negedge aclk);
        #1;
        chk("rst_ready", s_tready, 1);
        chk("rst_valid", m_iq_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cid", counter_id, 0);
        chk("rst_tc", timeout_count, 0);
        chk("rst_thr_i", threshold_ctrl_i, 0);

        @(negedge aclk);
        aresetn = 1'b1; s_tvalid = 1'b1; s_adc_tdata = 32'h12345678;
        #1;
        chk("idle_ready", s_tready, 1);
        chk("idle_valid", m_iq_tvalid, 0);
        @(negedge aclk);
        enable = 1'b1; s_tvalid = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        check_load(0);

        // Frame 0: plain frame, timeout disabled through a long wait
        run_frame(16, 0, 0, -1, 16);
        next_cycle();
        chk("cid_f0", counter_id, 1);
        chk("wait_tlast", m_iq_tlast, 0);
        chk("wait_ready", s_tready, 1);
        repeat (28) next_cycle();
        chk("tc_disabled", timeout_count, 0);
        chk("busy_wait", busy, 1);
        pk_cycle();
        check_load(0);

        // Frame 1: backpressure, then timeout after exactly 20 wait cycles
        frame_timeout_cycles = 20;
        run_frame(16, 1, 1, -1, 16);
        for (int w = 1; w <= 20; w++) begin
            next_cycle();
            if (w == 1) chk("cid_f1", counter_id, 2);
        end
        chk("tc_before_timeout", timeout_count, 0);
        chk("busy_w20", busy, 1);
        check_load(1);

        // Frame 2: early chirp end with padding, handshake collides with timeout
        run_frame(10, 1, 2, -1, 16);
        repeat (19) next_cycle();
        pk_cycle();
        check_load(1);

        // Frame 3: enable dropped mid-frame, frame completes then idles
        run_frame(16, 0, 3, 5, 16);
        next_cycle();
        next_cycle();
        pk_cycle();
        next_cycle();
        chk("post_busy", busy, 0);
        chk("post_ready", s_tready, 1);
        chk("post_cid", counter_id, 4);
        chk("post_tc", timeout_count, 1);
        repeat (3) next_cycle();
        chk("stay_idle", busy, 0);
        @(negedge aclk);
        enable = 1'b1;
        #1;
        check_load(1);

        // Frame 4: reset lands on sample 7
        run_frame(16, 0, 4, -1, 7);
        @(negedge aclk);
        aresetn = 1'b0; s_tvalid = 1'b1; chirp_active = 1'b1;
        #1;
        chk("ar_valid", m_iq_tvalid, 0);
        chk("ar_tlast", m_iq_tlast, 0);
        chk("ar_first", m_iq_first, 0);
        chk("ar_ready", s_tready, 1);
        chk("ar_busy", busy, 0);
        chk("ar_cid", counter_id, 0);
        chk("ar_tc", timeout_count, 0);
        chk("ar_thr_q", threshold_ctrl_q, 0);
        @(negedge aclk);
        #1;
        @(negedge aclk);
        aresetn = 1'b1; s_tvalid = 1'b0; chirp_active = 1'b0;
        #1;
        chk("rel_busy", busy, 0);
        check_load(0);
        run_frame(16, 1, 0, -1, 16);
        next_cycle();
        chk("cid_after_reset", counter_id, 1);
        pk_cycle();
        repeat (2) next_cycle();
        chk("sb_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
